// File: rtl/d_cache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with 1-bit LRU per set.
// The 0xA000_0000-0xBFFF_FFFF window bypasses the arrays as a combinational pass-through.
module d_cache_2way #(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic [31:0]        p_dout,
    output logic [31:0]        p_din,
    input  logic               p_strobe,
    input  logic [3:0]         p_wen,
    input  logic [1:0]         p_size,
    input  logic               p_rw,
    output logic               p_ready,
    output logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_dout,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    input  logic               m_ready
);
    localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
    localparam int SETS    = 1 << C_INDEX;
    localparam int WORDS   = 1 << C_OFFSET;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RF} state_t;

    state_t                 state_q, state_d;
    logic [C_OFFSET-1:0]    cnt_q, cnt_d;
    logic                   victim_q, victim_d;
    logic [1:0][SETS-1:0]   valid_q, dirty_q;
    logic [SETS-1:0]        lru_q;
    logic [T_WIDTH-1:0]     tag_mem  [2][SETS];
    logic [31:0]            data_mem [2][SETS*WORDS];

    logic [C_OFFSET-1:0] word_sel;
    logic [C_INDEX-1:0]  index;
    logic [T_WIDTH-1:0]  tag;
    logic                uncached, hit0, hit1, hit, hit_way, cached_req, do_hit;
    logic                last, miss_victim;
    logic [31:0]         hit_word, victim_word, wmask;

    assign word_sel    = p_a[C_OFFSET+1:2];
    assign index       = p_a[C_OFFSET+C_INDEX+1:C_OFFSET+2];
    assign tag         = p_a[A_WIDTH-1 -: T_WIDTH];
    assign uncached    = (p_a[A_WIDTH-1 -: 3] == 3'b101);
    assign hit0        = valid_q[0][index] && (tag_mem[0][index] == tag);
    assign hit1        = valid_q[1][index] && (tag_mem[1][index] == tag);
    assign hit         = hit0 | hit1;
    assign hit_way     = ~hit0;
    assign cached_req  = (state_q == S_IDLE) && p_strobe && !uncached;
    assign do_hit      = cached_req && hit;
    assign last        = &cnt_q;
    assign hit_word    = data_mem[hit_way][{index, word_sel}];
    assign victim_word = data_mem[victim_q][{index, cnt_q}];
    assign wmask       = {{8{p_wen[3]}}, {8{p_wen[2]}}, {8{p_wen[1]}}, {8{p_wen[0]}}};
    // Prefer an empty way; only when both are valid does the LRU bit pick the victim.
    assign miss_victim = !valid_q[0][index] ? 1'b0 :
                         !valid_q[1][index] ? 1'b1 : lru_q[index];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        victim_d = victim_q;
        case (state_q)
            S_IDLE: begin
                if (cached_req && !hit) begin
                    victim_d = miss_victim;
                    cnt_d    = '0;
                    state_d  = (valid_q[miss_victim][index] && dirty_q[miss_victim][index])
                               ? S_WB : S_RF;
                end
            end
            S_WB: begin
                if (m_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = S_RF;
                end
            end
            S_RF: begin
                if (m_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus handshake: m_strobe and the m_* qualifiers stay stable until the cycle m_ready is
    // high; that cycle's rising edge completes exactly one word.
    always_comb begin
        p_din    = '0;
        p_ready  = 1'b0;
        m_a      = '0;
        m_din    = '0;
        m_strobe = 1'b0;
        m_wen    = 4'b0000;
        m_size   = 2'b00;
        m_rw     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (uncached) begin
                    m_a      = {3'b000, p_a[A_WIDTH-4:0]};
                    m_din    = p_dout;
                    m_wen    = p_wen;
                    m_size   = p_size;
                    m_rw     = p_rw;
                    m_strobe = p_strobe;
                    p_din    = p_strobe ? m_dout : 32'd0;
                    p_ready  = p_strobe && m_ready;
                end else if (do_hit) begin
                    p_ready = 1'b1;
                    p_din   = hit_word;
                end
            end
            S_WB: begin
                m_a      = {tag_mem[victim_q][index], index, cnt_q, 2'b00};
                m_din    = victim_word;
                m_wen    = 4'b1111;
                m_size   = 2'b10;
                m_rw     = 1'b1;
                m_strobe = 1'b1;
            end
            S_RF: begin
                m_a      = {tag, index, cnt_q, 2'b00};
                m_size   = 2'b10;
                m_strobe = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            m_strobe = 1'b0;
            p_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            victim_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (do_hit) begin
                lru_q[index] <= ~hit_way;
                if (p_rw) dirty_q[hit_way][index] <= 1'b1;
            end
            if (state_q == S_WB && m_ready && last) dirty_q[victim_q][index] <= 1'b0;
            if (state_q == S_RF && m_ready && last) begin
                valid_q[victim_q][index] <= 1'b1;
                dirty_q[victim_q][index] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits make stale contents invisible.
    always_ff @(posedge clk) begin
        if (!rst && do_hit && p_rw)
            data_mem[hit_way][{index, word_sel}] <= (hit_word & ~wmask) | (p_dout & wmask);
        if (!rst && state_q == S_RF && m_ready) begin
            data_mem[victim_q][{index, cnt_q}] <= m_dout;
            if (last) tag_mem[victim_q][index] <= tag;
        end
    end
endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way: a word-wide bus memory model logs every transaction,
// and each access is checked against hand-computed addresses and data.
module tb_d_cache_2way;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] p_a, p_dout, p_din;
    logic        p_strobe, p_rw, p_ready;
    logic [3:0]  p_wen;
    logic [1:0]  p_size;
    logic [31:0] m_a, m_dout, m_din;
    logic        m_strobe, m_rw, m_ready;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] log_a [$];
    logic [31:0] log_d [$];
    logic        log_rw [$];

    d_cache_2way dut (
        .clk(clk), .rst(rst),
        .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
        .p_wen(p_wen), .p_size(p_size), .p_rw(p_rw), .p_ready(p_ready),
        .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe),
        .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: answers each strobe with a one-cycle m_ready pulse.
    initial begin
        m_ready = 1'b0;
        m_dout  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (m_strobe && !m_ready) begin
                m_ready = 1'b1;
                log_a.push_back(m_a);
                log_rw.push_back(m_rw);
                if (m_rw) begin
                    log_d.push_back(m_din);
                    mem_m[m_a] = m_din;
                end else begin
                    m_dout = mem_rd(m_a);
                    log_d.push_back(m_dout);
                end
            end else begin
                m_ready = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_rw.delete();
    endtask

    task automatic check_burst(input string tag, input int first, input logic [31:0] base,
                               input logic rw);
        for (int i = 0; i < 4; i++) begin
            if (first + i < log_a.size()) begin
                check($sformatf("%s_a%0d", tag, i), log_a[first+i], base + 32'(4 * i));
                check($sformatf("%s_rw%0d", tag, i), 32'(log_rw[first+i]), 32'(rw));
            end
        end
    endtask

    task automatic cpu_access(input string tag, input logic rw, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] wen,
                              output logic [31:0] rdata, output int cycles);
        @(posedge clk);
        #1;
        p_a = a; p_dout = d; p_wen = wen; p_size = 2'b10; p_rw = rw; p_strobe = 1'b1;
        cycles = 0;
        @(negedge clk);
        while (!p_ready && cycles < 400) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_rdy"}, 32'(p_ready), 32'd1);
        rdata = p_din;
        @(posedge clk);
        #1;
        p_strobe = 1'b0; p_rw = 1'b0; p_wen = 4'b0000;
    endtask

    logic [31:0] rd;
    int          cyc;
    int          guard;

    initial begin
        rst = 1'b1;
        p_a = '0; p_dout = '0; p_strobe = 1'b0; p_wen = '0; p_size = '0; p_rw = 1'b0;
        mem_m[32'h1000] = 32'h11;
        mem_m[32'h1004] = 32'h22;
        mem_m[32'h1008] = 32'h33;
        mem_m[32'h100C] = 32'h44;
        repeat (3) @(negedge clk);
        check("rst_p_ready", 32'(p_ready), 32'd0);
        check("rst_m_strobe", 32'(m_strobe), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_p_ready", 32'(p_ready), 32'd0);
        check("idle_p_din", p_din, 32'd0);

        // Clean miss refill, then a hit with no bus traffic
        clear_log();
        cpu_access("t1_rd", 1'b0, 32'h0000_1004, '0, 4'b0000, rd, cyc);
        check("t1_data", rd, 32'h22);
        check("t1_stalled", 32'(cyc != 0), 32'd1);
        check("t1_nbus", log_a.size(), 32'd4);
        check_burst("t1", 0, 32'h1000, 1'b0);
        clear_log();
        cpu_access("t1_hit", 1'b0, 32'h0000_100C, '0, 4'b0000, rd, cyc);
        check("t1_hit_data", rd, 32'h44);
        check("t1_hit_cyc", cyc, 32'd0);
        check("t1_hit_nbus", log_a.size(), 32'd0);

        // Byte write hit
        cpu_access("t2_wr", 1'b1, 32'h0000_1000, 32'h00AB_0000, 4'b0100, rd, cyc);
        check("t2_wr_cyc", cyc, 32'd0);
        check("t2_wr_nbus", log_a.size(), 32'd0);
        cpu_access("t2_rd", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t2_rd_data", rd, 32'h00AB_0011);

        // Second way fill, then a clean LRU victim
        cpu_access("t3_fill", 1'b0, 32'h0000_2000, '0, 4'b0000, rd, cyc);
        check("t3_fill_data", rd, 32'hC0DE_2000);
        check("t3_fill_nbus", log_a.size(), 32'd4);
        check_burst("t3_fill", 0, 32'h2000, 1'b0);
        cpu_access("t3_hit1000", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t3_hit1000_cyc", cyc, 32'd0);
        clear_log();
        cpu_access("t3_rd3000", 1'b0, 32'h0000_3000, '0, 4'b0000, rd, cyc);
        check("t3_rd3000_data", rd, 32'hC0DE_3000);
        check("t3_rd3000_nbus", log_a.size(), 32'd4);
        check_burst("t3_rd3000", 0, 32'h3000, 1'b0);
        clear_log();
        cpu_access("t3_still", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t3_still_data", rd, 32'h00AB_0011);
        check("t3_still_cyc", cyc, 32'd0);
        cpu_access("t3_hit3000", 1'b0, 32'h0000_3000, '0, 4'b0000, rd, cyc);
        check("t3_hit3000_cyc", cyc, 32'd0);
        check("t3_hits_nbus", log_a.size(), 32'd0);

        // Dirty eviction of the 0x1000 line
        cpu_access("t4_rd", 1'b0, 32'h0000_4000, '0, 4'b0000, rd, cyc);
        check("t4_data", rd, 32'hC0DE_4000);
        check("t4_nbus", log_a.size(), 32'd8);
        check_burst("t4_wb", 0, 32'h1000, 1'b1);
        check_burst("t4_rf", 4, 32'h4000, 1'b0);
        if (log_d.size() >= 4) begin
            check("t4_wb_d0", log_d[0], 32'h00AB_0011);
            check("t4_wb_d1", log_d[1], 32'h22);
            check("t4_wb_d3", log_d[3], 32'h44);
        end
        clear_log();
        cpu_access("t4_back", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t4_back_data", rd, 32'h00AB_0011);
        check("t4_back_nbus", log_a.size(), 32'd4);

        // Uncached pass-through
        clear_log();
        cpu_access("t5_wr", 1'b1, 32'hBFD0_0010, 32'hDEAD_BEEF, 4'b1111, rd, cyc);
        check("t5_nbus", log_a.size(), 32'd1);
        if (log_a.size() >= 1) begin
            check("t5_m_a", log_a[0], 32'h1FD0_0010);
            check("t5_m_rw", 32'(log_rw[0]), 32'd1);
            check("t5_m_din", log_d[0], 32'hDEAD_BEEF);
        end
        clear_log();
        cpu_access("t5_rd", 1'b0, 32'hA000_1000, '0, 4'b0000, rd, cyc);
        check("t5_rd_data", rd, 32'h00AB_0011);
        if (log_a.size() >= 1) check("t5_rd_m_a", log_a[0], 32'h0000_1000);
        clear_log();
        cpu_access("t5_cached", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t5_cached_cyc", cyc, 32'd0);
        check("t5_cached_nbus", log_a.size(), 32'd0);

        // Reset in the middle of a refill
        clear_log();
        @(posedge clk);
        #1;
        p_a = 32'h0000_5000; p_rw = 1'b0; p_size = 2'b10; p_strobe = 1'b1;
        @(negedge clk);
        check("t6_miss_rdy", 32'(p_ready), 32'd0);
        check("t6_miss_din", p_din, 32'd0);
        guard = 0;
        while (!(log_a.size() == 2 && !m_ready) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("t6_pre_strobe", 32'(m_strobe), 32'd1);
        check("t6_pre_m_a", m_a, 32'h0000_5008);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_strobe", 32'(m_strobe), 32'd0);
        check("t6_rst_p_ready", 32'(p_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        guard = 0;
        @(negedge clk);
        while (!p_ready && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        check("t6_rdy", 32'(p_ready), 32'd1);
        check("t6_data", p_din, 32'hC0DE_5000);
        check("t6_nbus", log_a.size(), 32'd4);
        check_burst("t6", 0, 32'h5000, 1'b0);
        @(posedge clk);
        #1;
        p_strobe = 1'b0;
        cpu_access("t6_1000", 1'b0, 32'h0000_1000, '0, 4'b0000, rd, cyc);
        check("t6_1000_miss", 32'(cyc != 0), 32'd1);
        check("t6_1000_data", rd, 32'h00AB_0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
